pipe_fetch_ctrl: RTL
====================

Name: pipe_fetch_ctrl

Overview:
Fetch-stage sequencer for the 5-stage MIPS pipeline.
- Drives the PC-select, stall and flush controls of the IF stage and of the IF/ID and ID/EX pipeline registers.
- Arbitrates three sources: the EX-stage branch redirect, the ID-stage jump redirect, and the load-use hazard.
- Holds the front end for a multi-cycle mult/div through a counted wait state.

Parameters:
MDU_CYCLES, 32, total cycles a mult/div occupies EX (legal range 2..255).
CNT_W, 8, width of the MDU countdown counter.

Ports:
in_clk  input  1  clock; all state updates on the rising edge
in_rst  input  1  synchronous reset, active-low
in_ex_branch_taken  input  1  branch in EX resolved taken
in_ex_baddr  input  32  branch target from EX
in_id_jump  input  1  j/jal/jr decoded in ID
in_id_jaddr  input  32  jump target from ID
in_id_rs  input  5  ID source register rs
in_id_rt  input  5  ID source register rt
in_id_uses_rs  input  1  ID instruction reads rs
in_id_uses_rt  input  1  ID instruction reads rt
in_ex_memread  input  1  EX instruction is a load
in_ex_rd  input  5  EX destination register
in_id_mdu_start  input  1  ID instruction is mult/div
out_pc_sel  output  2  00 = npc, 01 = branch, 10 = jump (11 never driven)
out_pc_baddr  output  32  forwarded branch target
out_pc_jaddr  output  32  forwarded jump target
out_stall  output  1  hold PC and IF/ID
out_flush_ifid  output  1  clear IF/ID to a nop
out_flush_idex  output  1  clear ID/EX to a nop (bubble)
out_mdu_busy  output  1  registered; high during MDU_WAIT

Behaviour:
- States: RUN, MDU_WAIT. Counter cnt is CNT_W bits. The state register is the only sequential element besides cnt.
- Reset: while in_rst==0 at a clock edge, state becomes RUN and cnt becomes 0. While in_rst==0, all control outputs are forced to 0 combinationally. out_pc_baddr and out_pc_jaddr always pass their inputs through.
- Control outputs are combinational from state and inputs (zero latency), so the PC mux is steered in the same cycle.
- Load-use hazard (lu): in_ex_memread AND in_ex_rd!=0 AND ((in_id_uses_rs AND in_id_rs==in_ex_rd) OR (in_id_uses_rt AND in_id_rt==in_ex_rd)).
- RUN priority, highest first:
  1. in_ex_branch_taken: pc_sel=01, flush_ifid=1, flush_idex=1, stall=0. Any jump, lu or mdu_start in the same cycle is discarded.
  2. lu: stall=1, flush_idex=1, pc_sel=00. A coincident jump is deferred; it re-presents next cycle because ID is held.
  3. in_id_jump: pc_sel=10, flush_ifid=1.
  4. in_id_mdu_start: next state MDU_WAIT, cnt<=MDU_CYCLES-1. No stall in this cycle; the mult/div advances into EX.
  5. Otherwise: all outputs 0.
- MDU_WAIT: stall=1, flush_idex=1, pc_sel=00.
  - cnt decrements by 1 each cycle.
  - When cnt==1 at an edge, the next state is RUN and cnt becomes 0, so the wait lasts MDU_CYCLES-1 cycles.
  - All redirect, lu and mdu_start inputs are ignored in this state.
- in_id_mdu_start together with in_id_jump cannot occur (decoder-exclusive). If both are asserted, the jump wins and mdu_start is dropped.
- out_mdu_busy = (state==MDU_WAIT).
- Reset asserted mid-MDU_WAIT aborts the wait immediately; the next cycle is RUN with stall=0.

Optional Feature:
Macro PIPE_FETCH_PERF_EN.
- Defined: adds three 32-bit saturating counters and matching output ports out_perf_stall, out_perf_flush and out_perf_mdu. They count, respectively:
  - cycles with stall=1 in RUN;
  - cycles with flush_ifid=1;
  - cycles in MDU_WAIT.
  - All three clear on reset and hold at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - PC_SEL_NPC=2'b00, PC_SEL_BRANCH=2'b01, PC_SEL_JUMP=2'b10;
  - the state encoding RUN=1'b0, MDU_WAIT=1'b1.
- One sub-module, load_use_detect: purely combinational lu equation, instantiated once.

Test Plan:
- Reset: hold in_rst=0 for 3 cycles with in_ex_branch_taken=1 → all control outputs 0, out_mdu_busy=0. Release → branch takes effect the same cycle (pc_sel=01).
- Load-use: in_ex_memread=1, in_ex_rd=8, in_id_rs=8, in_id_uses_rs=1 → stall=1, flush_idex=1, pc_sel=00 for exactly 1 cycle. Repeat with in_ex_rd=0 → no stall.
- Priority: in_ex_branch_taken=1, in_id_jump=1 and lu in the same cycle → pc_sel=01, flush_ifid=flush_idex=1, stall=0. Next cycle, jump alone → pc_sel=10, flush_ifid=1.
- Jump under lu: jump + lu → cycle 1 stall=1 and pc_sel=00; cycle 2 (lu cleared) pc_sel=10.
- MDU: MDU_CYCLES=4, pulse in_id_mdu_start → out_mdu_busy=1 and stall=1 for exactly 3 cycles. A branch asserted during this window is ignored.
- Reset mid-wait: in_rst=0 during the 2nd MDU_WAIT cycle → next cycle state RUN, out_mdu_busy=0. With PIPE_FETCH_PERF_EN defined, all perf counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the fetch-stage sequencer: PC mux selects, FSM states,
// the bundled control word and a saturating increment helper.
package pipe_ctrl_pkg;

    localparam logic [1:0] PC_SEL_NPC    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [1:0] pc_sel;
        logic       stall;
        logic       flush_ifid;
        logic       flush_idex;
    } fetch_ctrl_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: the ID instruction reads a register that the load in EX
// has not yet produced. r0 never creates a hazard.
module load_use_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit = id_uses_rt && (id_rt == ex_rd);
    assign lu     = ex_memread && (ex_rd != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates branch/jump redirects and load-use stalls,
// and holds the front end through a counted mult/div wait. Optional perf
// counters are built when PIPE_FETCH_PERF_EN is defined.
module pipe_fetch_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_ex_branch_taken,
    input  logic [31:0] in_ex_baddr,
    input  logic        in_id_jump,
    input  logic [31:0] in_id_jaddr,
    input  logic [4:0]  in_id_rs,
    input  logic [4:0]  in_id_rt,
    input  logic        in_id_uses_rs,
    input  logic        in_id_uses_rt,
    input  logic        in_ex_memread,
    input  logic [4:0]  in_ex_rd,
    input  logic        in_id_mdu_start,
    output logic [1:0]  out_pc_sel,
    output logic [31:0] out_pc_baddr,
    output logic [31:0] out_pc_jaddr,
    output logic        out_stall,
    output logic        out_flush_ifid,
    output logic        out_flush_idex,
    output logic        out_mdu_busy
`ifdef PIPE_FETCH_PERF_EN
    ,
    output logic [31:0] out_perf_stall,
    output logic [31:0] out_perf_flush,
    output logic [31:0] out_perf_mdu
`endif
);

    fetch_state_e     state;
    logic [CNT_W-1:0] cnt;
    fetch_ctrl_t      ctrl;
    logic             lu;
    logic             mdu_go;

    load_use_detect u_lu (
        .ex_memread (in_ex_memread),
        .ex_rd      (in_ex_rd),
        .id_rs      (in_id_rs),
        .id_rt      (in_id_rt),
        .id_uses_rs (in_id_uses_rs),
        .id_uses_rt (in_id_uses_rt),
        .lu         (lu)
    );

    // Zero-latency arbitration so the PC mux is steered in the same cycle.
    always_comb begin
        ctrl   = '0;
        mdu_go = 1'b0;
        if (state == MDU_WAIT) begin
            ctrl.stall      = 1'b1;
            ctrl.flush_idex = 1'b1;
        end else if (in_ex_branch_taken) begin
            ctrl.pc_sel     = PC_SEL_BRANCH;
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
        end else if (lu) begin
            // A coincident jump stays in ID and re-presents next cycle.
            ctrl.stall      = 1'b1;
            ctrl.flush_idex = 1'b1;
        end else if (in_id_jump) begin
            ctrl.pc_sel     = PC_SEL_JUMP;
            ctrl.flush_ifid = 1'b1;
        end else if (in_id_mdu_start) begin
            mdu_go = 1'b1;
        end
        if (!in_rst) begin
            ctrl   = '0;
            mdu_go = 1'b0;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mdu_go) begin
                        state <= MDU_WAIT;
                        cnt   <= CNT_W'(MDU_CYCLES - 1);
                    end
                end
                MDU_WAIT: begin
                    // The mult/div already spent one cycle in EX on entry.
                    if (cnt <= CNT_W'(1)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign out_pc_sel     = ctrl.pc_sel;
    assign out_stall      = ctrl.stall;
    assign out_flush_ifid = ctrl.flush_ifid;
    assign out_flush_idex = ctrl.flush_idex;
    assign out_mdu_busy   = (state == MDU_WAIT);
    assign out_pc_baddr   = in_ex_baddr;
    assign out_pc_jaddr   = in_id_jaddr;

`ifdef PIPE_FETCH_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
    logic [31:0] perf_mdu;

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_mdu   <= '0;
        end else begin
            if ((state == RUN) && ctrl.stall) perf_stall <= sat_inc32(perf_stall);
            if (ctrl.flush_ifid)              perf_flush <= sat_inc32(perf_flush);
            if (state == MDU_WAIT)            perf_mdu   <= sat_inc32(perf_mdu);
        end
    end

    assign out_perf_stall = perf_stall;
    assign out_perf_flush = perf_flush;
    assign out_perf_mdu   = perf_mdu;
`endif

endmodule
